// File: rtl/par_to_ser_lanes_pkg.sv
// Shared helpers for the parallel-to-serial lane converter.
package p2s_pkg;

  // Number of serial beats needed to send one word.
  function automatic int p2s_beats(int n, int l);
    return n / l;
  endfunction

  // Width of the beat counter; never narrower than one bit.
  function automatic int p2s_cnt_w(int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // A lane must be non-empty and tile the word exactly.
  function automatic bit p2s_legal(int n, int l);
    return (l > 0) && (n >= l) && ((n % l) == 0);
  endfunction

endpackage

// File: rtl/par_to_ser_lanes_if.sv
// Word-side and serial-side handshake bundle.
interface par_to_ser_lanes_if #(
  parameter int N = 8,
  parameter int L = 1
);
  logic [N-1:0] par_data;
  logic         par_valid;
  logic         par_ready;
  logic [L-1:0] ser_data;
  logic         ser_valid;
  logic         ser_ready;
  logic         ser_last;

  // Environment view: drives words in and accepts beats out.
  modport master (
    output par_data, par_valid, ser_ready,
    input  par_ready, ser_data, ser_valid, ser_last
  );

  // Converter view.
  modport slave (
    input  par_data, par_valid, ser_ready,
    output par_ready, ser_data, ser_valid, ser_last
  );
endinterface

// File: rtl/par_to_ser_lanes_hold_buf.sv
// One-entry holding register so a word can wait while the shifter drains.
module p2s_hold_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         unload,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         vld
);

  // load and unload never coincide: load needs the buffer empty, unload needs it full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
      vld  <= 1'b0;
    end else if (load) begin
      dout <= din;
      vld  <= 1'b1;
    end else if (unload) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/par_to_ser_lanes.sv
// Parallel-to-serial converter: N-bit words out as N/L lanes of L bits.
module par_to_ser_lanes
  import p2s_pkg::*;
#(
  parameter int N         = 8,
  parameter int L         = 1,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  par_to_ser_lanes_if.slave  bus,
  output logic [CNT_W-1:0]   word_cnt
);

  localparam int             BEATS    = p2s_beats(N, L);
  localparam int             CW       = p2s_cnt_w(BEATS);
  localparam logic [CW-1:0]  LAST_CNT = CW'(BEATS - 1);

  if (!p2s_legal(N, L)) begin : g_bad_cfg
    $error("par_to_ser_lanes: N must be a positive multiple of L");
  end

  logic [N-1:0]  sh, shifted, hold_data, load_word;
  logic [L-1:0]  lane;
  logic [CW-1:0] cnt;
  logic          busy, hold_v;
  logic          accept, xfer, last_xfer, free;
  logic          to_hold, from_hold, load;

  // Output end of the shifter and the shift direction follow bit order.
  if (MSB_FIRST != 0) begin : g_msb
    assign lane    = sh[N-1 -: L];
    assign shifted = sh << L;
  end else begin : g_lsb
    assign lane    = sh[L-1:0];
    assign shifted = sh >> L;
  end

  assign bus.par_ready = !hold_v && !rst;
  assign bus.ser_valid = busy;
  assign bus.ser_data  = busy ? lane : '0;
  assign bus.ser_last  = busy && (cnt == LAST_CNT);

  assign accept    = bus.par_valid && bus.par_ready;
  assign xfer      = busy && bus.ser_ready;
  assign last_xfer = xfer && (cnt == LAST_CNT);
  // Shifter can take a new word at this edge if idle or finishing its last beat.
  assign free      = !busy || last_xfer;
  assign to_hold   = accept && !free;
  assign from_hold = free && hold_v;
  // accept implies hold empty, so a direct load and a hold unload are exclusive.
  assign load      = from_hold || (accept && free);
  assign load_word = hold_v ? hold_data : bus.par_data;

  p2s_hold_buf #(.W(N)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .load   (to_hold),
    .unload (from_hold),
    .din    (bus.par_data),
    .dout   (hold_data),
    .vld    (hold_v)
  );

  // Shifter, beat counter and completed-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh       <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      word_cnt <= '0;
    end else begin
      if (load) begin
        sh   <= load_word;
        cnt  <= '0;
        busy <= 1'b1;
      end else if (xfer) begin
        sh <= shifted;
        if (last_xfer) begin
          cnt  <= '0;
          busy <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (last_xfer)
        word_cnt <= word_cnt + 1'b1;
    end
  end

endmodule
